mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-client arbiter between the pipelined datapath's instruction port (i_mem_*) and
//  data port (d_mem_*) and a single-ported physical memory (pmem_*). Sits directly
//  downstream of cpu_datapath. Serialises fetch and load/store traffic so both pipeline
//  stages share one memory. One transaction is in flight at a time; handshake is read/write + resp.
// PARAMETERS
//  WIDTH   16  address/data width (lc3b_word)
//  MASK_W  2   byte-enable width (lc3b_mem_wmask)
// PORTS
//  clk               in   1       rising-edge clock
//  reset             in   1       synchronous, active-high reset
//  i_mem_read        in   1       instruction fetch request (level, held until i_mem_resp)
//  i_mem_address     in   WIDTH   fetch address
//  i_mem_rdata       out  WIDTH   fetch data, valid while i_mem_resp=1
//  i_mem_resp        out  1       one-cycle completion pulse to I client
//  d_mem_read        in   1       data read request (level, held until d_mem_resp)
//  d_mem_write       in   1       data write request (level, held until d_mem_resp)
//  d_mem_address     in   WIDTH   data address
//  d_mem_wdata       in   WIDTH   store data
//  d_mem_byte_enable in   MASK_W  store byte mask
//  d_mem_rdata       out  WIDTH   load data, valid while d_mem_resp=1
//  d_mem_resp        out  1       one-cycle completion pulse to D client
//  pmem_read         out  1       memory read strobe
//  pmem_write        out  1       memory write strobe
//  pmem_address      out  WIDTH   captured address of granted client
//  pmem_wdata        out  WIDTH   captured store data
//  pmem_byte_enable  out  MASK_W  captured mask; all-ones for reads
//  pmem_rdata        in   WIDTH   memory read data
//  pmem_resp         in   1       memory completion (one cycle)
// BEHAVIOUR
//  - FSM: IDLE, I_BUSY, D_BUSY. Reset (synchronous, active-high) -> IDLE; all outputs 0,
//    capture regs cleared, rr pointer = D.
//  - IDLE: if any request, grant per priority, capture address/wdata/mask/rw of winner
//    into regs at the clock edge, go to *_BUSY. No pmem strobe is driven in IDLE.
//  - *_BUSY: pmem_read/pmem_write driven from captured rw (registered, glitch-free);
//    pmem_address/wdata/byte_enable held from capture regs, stable for the whole transaction.
//  - pmem_resp in *_BUSY: same-cycle combinational pass of resp and pmem_rdata to granted
//    client only; other client's resp stays 0 and its rdata = 0. Next state IDLE.
//  - Latency: request seen in cycle N -> strobe from N+1 -> resp same cycle as pmem_resp.
//    Minimum 1 IDLE turnaround cycle between back-to-back transactions.
//  - Client rule: request held until resp; changes to address/data after grant are ignored.
//    Request withdrawn before grant is never issued.
//  - d_mem_read & d_mem_write both high: treated as write; read ignored.
//  - pmem_resp in IDLE: ignored, no client resp.
//  - Reset mid-transaction: next cycle IDLE, strobes drop, in-flight access abandoned,
//    no resp to any client.
//  - Simultaneous I and D requests in IDLE: resolved by priority (see CONFIGURATION).
// CONFIGURATION
//  ARB_RR_EN defined: round-robin. 1-bit pointer names the last-granted client; on a tie
//    the other client wins. Pointer updates on each grant.
//  ARB_RR_EN undefined: fixed priority, D always beats I (drains MEM stage before fetch).
//    No pointer register.
// TESTING
//  1 I only: i_mem_read=1, addr=0x0040; pmem_resp after 3 cycles, rdata=0x1234 ->
//    pmem_read=1 and addr=0x0040 from cycle 1; i_mem_resp=1 and i_mem_rdata=0x1234 in the
//    resp cycle; d_mem_resp=0.
//  2 D write: addr=0x0102, wdata=0xBEEF, be=2'b10 -> pmem_write=1 with those values held
//    until pmem_resp; d_mem_resp pulses once.
//  3 Tie from IDLE, I and D both held: fixed mode -> D first, then IDLE, then I.
//    ARB_RR_EN -> grants alternate I,D,I,D over 4 transactions after reset (first = I).
//  4 Address change after grant: D addr 0x0200 -> 0x0300 one cycle after grant ->
//    pmem_address stays 0x0200.
//  5 Reset asserted in D_BUSY before pmem_resp -> next cycle strobes=0, FSM IDLE; late
//    pmem_resp produces no d_mem_resp.
//  6 Stray pmem_resp=1 in IDLE -> i_mem_resp=d_mem_resp=0, state unchanged.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the instruction client (i_mem_*), data client (d_mem_*) and
//   physical memory (pmem_*) signals that surround mem_arbiter.
//
//   modport slave  : arbiter view. Takes client requests and memory responses;
//                    drives client responses and memory strobes.
//   modport master : environment view (datapath + memory model), the mirror image.
//
//   Parameters
//     WIDTH  : address/data width
//     MASK_W : byte-enable width
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int WIDTH  = 16,
  parameter int MASK_W = 2
);
  // Instruction client
  logic              i_mem_read;
  logic [WIDTH-1:0]  i_mem_address;
  logic [WIDTH-1:0]  i_mem_rdata;
  logic              i_mem_resp;
  // Data client
  logic              d_mem_read;
  logic              d_mem_write;
  logic [WIDTH-1:0]  d_mem_address;
  logic [WIDTH-1:0]  d_mem_wdata;
  logic [MASK_W-1:0] d_mem_byte_enable;
  logic [WIDTH-1:0]  d_mem_rdata;
  logic              d_mem_resp;
  // Physical memory
  logic              pmem_read;
  logic              pmem_write;
  logic [WIDTH-1:0]  pmem_address;
  logic [WIDTH-1:0]  pmem_wdata;
  logic [MASK_W-1:0] pmem_byte_enable;
  logic [WIDTH-1:0]  pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_mem_read, i_mem_address,
    input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata, d_mem_byte_enable,
    input  pmem_rdata, pmem_resp,
    output i_mem_rdata, i_mem_resp,
    output d_mem_rdata, d_mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable
  );

  modport master (
    output i_mem_read, i_mem_address,
    output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata, d_mem_byte_enable,
    output pmem_rdata, pmem_resp,
    input  i_mem_rdata, i_mem_resp,
    input  d_mem_rdata, d_mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported physical memory between the datapath's
//   instruction-fetch client and load/store client. One transaction is in
//   flight at a time; the winner's address, store data, mask and direction are
//   captured at grant so the memory sees a stable request for the whole access.
//   Responses pass combinationally from pmem_resp/pmem_rdata to the granted
//   client only.
//
//   Ports
//     clk   : rising-edge clock
//     reset : synchronous, active-high reset
//     bus   : mem_arbiter_if.slave (i_mem_*, d_mem_*, pmem_* groups)
//
//   Configuration
//     ARB_RR_EN defined   : round-robin on ties, 1-bit last-granted pointer.
//     ARB_RR_EN undefined : fixed priority, D always beats I.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WIDTH  = 16,
  parameter int MASK_W = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              i_req, d_req, d_wins;
  logic              grant_i, grant_d;
  logic              resp_ok, i_resp, d_resp;

  logic [WIDTH-1:0]  addr_q, wdata_q;
  logic [MASK_W-1:0] be_q;
  logic              rd_q, wr_q;

  assign i_req = bus.i_mem_read;
  // A simultaneous read+write from the data client is a write.
  assign d_req = bus.d_mem_read | bus.d_mem_write;

`ifdef ARB_RR_EN
  // Names the client granted last (1 = D). On a tie the other client wins.
  logic last_d_q;
  assign d_wins = d_req & (~i_req | ~last_d_q);
`else
  assign d_wins = d_req;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / grant logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_wins) begin
          grant_d = 1'b1;
          state_d = D_BUSY;
        end else if (i_req) begin
          grant_i = 1'b1;
          state_d = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (bus.pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Capture registers and registered strobes. Loaded only on grant, so client
  // changes after the grant edge never reach the memory.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (grant_d) begin
      addr_q  <= bus.d_mem_address;
      wdata_q <= bus.d_mem_write ? bus.d_mem_wdata : '0;
      be_q    <= bus.d_mem_write ? bus.d_mem_byte_enable : '1;
      rd_q    <= ~bus.d_mem_write;
      wr_q    <= bus.d_mem_write;
    end else if (grant_i) begin
      addr_q  <= bus.i_mem_address;
      wdata_q <= '0;
      be_q    <= '1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b0;
    end else if (state_d == IDLE) begin
      // Transaction finished (or none pending): strobes drop, payload held.
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)        last_d_q <= 1'b1;
    else if (grant_d) last_d_q <= 1'b1;
    else if (grant_i) last_d_q <= 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.pmem_read        = rd_q;
  assign bus.pmem_write       = wr_q;
  assign bus.pmem_address     = addr_q;
  assign bus.pmem_wdata       = wdata_q;
  assign bus.pmem_byte_enable = be_q;

  // A response arriving while reset is held belongs to an abandoned access.
  assign resp_ok = bus.pmem_resp & ~reset;
  assign i_resp  = resp_ok & (state_q == I_BUSY);
  assign d_resp  = resp_ok & (state_q == D_BUSY);

  assign bus.i_mem_resp  = i_resp;
  assign bus.d_mem_resp  = d_resp;
  assign bus.i_mem_rdata = i_resp ? bus.pmem_rdata : '0;
  assign bus.d_mem_rdata = d_resp ? bus.pmem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed checks for reset, stray response, single fetch, write capture and
//   reset mid-transaction, followed by randomized rounds. In each round the
//   reference model decides the grant order from the priority rule and queues
//   the expected memory transactions; a monitor pops them as the DUT raises
//   its strobes and matches client responses against the data the memory
//   model returned.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int WIDTH  = 16;
  localparam int MASK_W = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_arbiter_if #(.WIDTH(WIDTH), .MASK_W(MASK_W)) bus ();

  mem_arbiter #(.WIDTH(WIDTH), .MASK_W(MASK_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic              is_d;
    logic              wr;
    logic [WIDTH-1:0]  addr;
    logic [WIDTH-1:0]  wdata;
    logic [MASK_W-1:0] be;
  } pm_t;

  int checks   = 0;
  int failures = 0;

  pm_t              exp_q[$];
  logic [WIDTH-1:0] rdata_q[$];

  bit   sb_on   = 1'b0;  // scoreboard monitor active
  bit   resp_en = 1'b0;  // memory responder active
  bit   last_d  = 1'b1;  // model: last granted client is D

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory responder: random 0..3 cycle delay, random read data.
  // ---------------------------------------------------------------------------
  initial begin
    bit active = 1'b0;
    int wait_left = 0;
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        if (bus.pmem_read || bus.pmem_write) begin
          if (!active) begin
            active    = 1'b1;
            wait_left = $urandom_range(0, 3);
          end
          if (wait_left == 0) begin
            bus.pmem_rdata = WIDTH'($urandom);
            bus.pmem_resp  = 1'b1;
            rdata_q.push_back(bus.pmem_rdata);
            active = 1'b0;
          end else begin
            wait_left--;
          end
        end else begin
          active = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: memory-side transactions first, then client responses.
  // ---------------------------------------------------------------------------
  pm_t              cur;
  bit               have_cur    = 1'b0;
  bit               prev_strobe = 1'b0;
  logic [WIDTH-1:0] exp_rd;

  always @(negedge clk) begin
    if (sb_on) begin
      if ((bus.pmem_read || bus.pmem_write) && !prev_strobe) begin
        if (exp_q.size() == 0) begin
          check("pmem_unexpected_txn", 1, 0);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
          check("pmem_address", bus.pmem_address, cur.addr);
          check("pmem_write",   bus.pmem_write,   cur.wr);
          check("pmem_read",    bus.pmem_read,    !cur.wr);
          check("pmem_be",      bus.pmem_byte_enable, cur.be);
          if (cur.wr) check("pmem_wdata", bus.pmem_wdata, cur.wdata);
        end
      end else if ((bus.pmem_read || bus.pmem_write) && have_cur) begin
        check("pmem_address_held", bus.pmem_address, cur.addr);
      end
      if (bus.i_mem_resp || bus.d_mem_resp) begin
        if (rdata_q.size() == 0 || !have_cur) begin
          check("resp_unexpected", 1, 0);
        end else begin
          exp_rd = rdata_q.pop_front();
          check("i_mem_resp", bus.i_mem_resp, !cur.is_d);
          check("d_mem_resp", bus.d_mem_resp, cur.is_d);
          check("granted_rdata", cur.is_d ? bus.d_mem_rdata : bus.i_mem_rdata, exp_rd);
          check("other_rdata",   cur.is_d ? bus.i_mem_rdata : bus.d_mem_rdata, 0);
          have_cur = 1'b0;
        end
      end
      prev_strobe = bus.pmem_read || bus.pmem_write;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // One randomized round: each client optionally issues one request.
  // ---------------------------------------------------------------------------
  task automatic run_round(input int n);
    bit  do_i, do_d, d_first, i_pend, d_pend;
    int  kind, cyc;
    pm_t ti, td;
    logic [MASK_W-1:0] raw_be;

    do_i = 1'($urandom_range(0, 1));
    do_d = 1'($urandom_range(0, 1));
    if (n < 4) begin
      do_i = 1'b1;
      do_d = 1'b1;
    end
    if (!do_i && !do_d) do_d = 1'b1;
    kind = $urandom_range(0, 2);  // 0 read, 1 write, 2 read+write

    raw_be   = MASK_W'($urandom);
    ti.is_d  = 1'b0;
    ti.wr    = 1'b0;
    ti.addr  = WIDTH'($urandom);
    ti.wdata = '0;
    ti.be    = '1;
    td.is_d  = 1'b1;
    td.wr    = (kind != 0);
    td.addr  = WIDTH'($urandom);
    td.wdata = WIDTH'($urandom);
    td.be    = td.wr ? raw_be : '1;

    // Reference arbitration.
    if (do_i && do_d) begin
`ifdef ARB_RR_EN
      d_first = !last_d;
`else
      d_first = 1'b1;
`endif
      if (d_first) begin exp_q.push_back(td); exp_q.push_back(ti); last_d = 1'b0; end
      else         begin exp_q.push_back(ti); exp_q.push_back(td); last_d = 1'b1; end
    end else begin
      d_first = do_d;
      exp_q.push_back(do_d ? td : ti);
      last_d = do_d;
    end

    @(posedge clk); #1;
    bus.i_mem_read        = do_i;
    bus.i_mem_address     = ti.addr;
    bus.d_mem_read        = do_d && (kind != 1);
    bus.d_mem_write       = do_d && (kind != 0);
    bus.d_mem_address     = td.addr;
    bus.d_mem_wdata       = td.wdata;
    bus.d_mem_byte_enable = raw_be;
    i_pend = do_i;
    d_pend = do_d;

    // Strobe appears the cycle after the request is seen in IDLE.
    @(posedge clk); #1;
    check("grant_latency",
          d_first ? (td.wr ? bus.pmem_write : bus.pmem_read) : bus.pmem_read, 1);
    // Winner scrambles its address after the grant; memory must not see it.
    if ($urandom_range(0, 1) == 1) begin
      if (d_first) bus.d_mem_address = ~td.addr;
      else         bus.i_mem_address = ~ti.addr;
    end

    cyc = 0;
    while ((i_pend || d_pend) && cyc < 64) begin
      bit drop_i, drop_d;
      @(negedge clk);
      drop_i = i_pend && bus.i_mem_resp;
      drop_d = d_pend && bus.d_mem_resp;
      @(posedge clk); #1;
      if (drop_i) begin bus.i_mem_read = 1'b0; i_pend = 1'b0; end
      if (drop_d) begin bus.d_mem_read = 1'b0; bus.d_mem_write = 1'b0; d_pend = 1'b0; end
      cyc++;
    end
    if (i_pend || d_pend) begin
      check("round_timeout", 1, 0);
      bus.i_mem_read  = 1'b0;
      bus.d_mem_read  = 1'b0;
      bus.d_mem_write = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset                 = 1'b1;
    bus.i_mem_read        = 1'b0;
    bus.i_mem_address     = '0;
    bus.d_mem_read        = 1'b0;
    bus.d_mem_write       = 1'b0;
    bus.d_mem_address     = '0;
    bus.d_mem_wdata       = '0;
    bus.d_mem_byte_enable = '0;
    bus.pmem_rdata        = '0;
    bus.pmem_resp         = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_pmem_read",    bus.pmem_read, 0);
    check("rst_pmem_write",   bus.pmem_write, 0);
    check("rst_pmem_address", bus.pmem_address, 0);
    check("rst_pmem_be",      bus.pmem_byte_enable, 0);
    check("rst_i_resp",       bus.i_mem_resp, 0);
    check("rst_d_resp",       bus.d_mem_resp, 0);

    // Stray pmem_resp in IDLE.
    @(posedge clk); #1;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 16'h55AA;
    @(negedge clk);
    check("stray_i_resp",  bus.i_mem_resp, 0);
    check("stray_d_resp",  bus.d_mem_resp, 0);
    check("stray_i_rdata", bus.i_mem_rdata, 0);
    @(posedge clk); #1;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    check("stray_no_strobe", {bus.pmem_read, bus.pmem_write}, 0);

    // Single fetch, memory answers in the third strobe cycle.
    bus.i_mem_read    = 1'b1;
    bus.i_mem_address = 16'h0040;
    @(posedge clk); #1;
    check("fetch_read_c1", bus.pmem_read, 1);
    check("fetch_addr_c1", bus.pmem_address, 16'h0040);
    check("fetch_be",      bus.pmem_byte_enable, 2'b11);
    @(posedge clk); #1;
    check("fetch_read_c2", bus.pmem_read, 1);
    @(posedge clk); #1;
    check("fetch_read_c3", bus.pmem_read, 1);
    check("fetch_no_resp_early", bus.i_mem_resp, 0);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 16'h1234;
    @(negedge clk);
    check("fetch_i_resp",  bus.i_mem_resp, 1);
    check("fetch_i_rdata", bus.i_mem_rdata, 16'h1234);
    check("fetch_d_resp",  bus.d_mem_resp, 0);
    check("fetch_d_rdata", bus.d_mem_rdata, 0);
    @(posedge clk); #1;
    bus.i_mem_read = 1'b0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    check("fetch_idle_after", bus.pmem_read, 0);

    // Write capture, late address change, then reset mid-transaction.
    @(posedge clk); #1;
    bus.d_mem_write       = 1'b1;
    bus.d_mem_address     = 16'h0200;
    bus.d_mem_wdata       = 16'hBEEF;
    bus.d_mem_byte_enable = 2'b10;
    @(posedge clk); #1;
    check("wr_strobe", bus.pmem_write, 1);
    check("wr_no_read", bus.pmem_read, 0);
    check("wr_addr",   bus.pmem_address, 16'h0200);
    check("wr_wdata",  bus.pmem_wdata, 16'hBEEF);
    check("wr_be",     bus.pmem_byte_enable, 2'b10);
    bus.d_mem_address = 16'h0300;
    @(posedge clk); #1;
    check("wr_addr_held", bus.pmem_address, 16'h0200);
    check("wr_strobe_held", bus.pmem_write, 1);
    reset           = 1'b1;
    bus.d_mem_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_strobes", {bus.pmem_read, bus.pmem_write}, 0);
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    check("rst_mid_late_d_resp", bus.d_mem_resp, 0);
    check("rst_mid_late_i_resp", bus.i_mem_resp, 0);
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    check("rst_mid_stays_idle", {bus.pmem_read, bus.pmem_write}, 0);

    // Randomized rounds; the reset above put the tie pointer back on D.
    last_d  = 1'b1;
    resp_en = 1'b1;
    sb_on   = 1'b1;
    for (int n = 0; n < 40; n++) run_round(n);
    repeat (3) @(posedge clk);
    sb_on   = 1'b0;
    resp_en = 1'b0;
    check("exp_txn_drained",  exp_q.size(), 0);
    check("rdata_q_drained",  rdata_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
